// File: rtl/snake_body_tracker.sv
// Snake game state plus double-buffered frame builder for an 8x8 LED matrix.
// Optional `SNAKE_WALL_KILL_EN: moving off an edge ends the game instead of wrapping.
module snake_body_tracker #(
  parameter int MAX_LEN   = 16,
  parameter int START_LEN = 3,
  localparam int PW = $clog2(MAX_LEN),
  localparam int LW = PW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 step,
  input  logic [1:0]           dir,
  input  logic                 food_valid,
  input  logic [2:0]           food_row,
  input  logic [2:0]           food_col,
  output logic [7:0][7:0]      red_array,
  output logic [7:0][7:0]      green_array,
  output logic                 ate,
  output logic                 game_over,
  output logic                 busy,
  output logic [LW-1:0]        length
);

  typedef enum logic [1:0] {S_RUN, S_RENDER, S_OVER} state_t;

  state_t          state_q;
  logic [5:0]      ring_q [MAX_LEN];
  logic [PW-1:0]   head_ptr_q;
  logic [LW-1:0]   length_q;
  logic [1:0]      heading_q;
  logic [LW-1:0]   cnt_q;
  logic [7:0][7:0] shadow_q, red_q, green_q;
  logic            ate_q, over_q, busy_q;

  logic [1:0]      heading_d;
  logic [5:0]      head_cur, seg, tail;
  logic [2:0]      nr, nc;
  logic            off_edge, food_hit, grow, hit;
  logic [PW-1:0]   tail_idx, seg_idx;
  logic [LW-1:0]   seg_k;
  logic [7:0][7:0] food_frame;

  // A reversal request keeps the old heading; otherwise dir is taken.
  always_comb begin
    heading_d = (dir == (heading_q ^ 2'b10)) ? heading_q : dir;
    head_cur  = ring_q[head_ptr_q];
    nr = head_cur[5:3];
    nc = head_cur[2:0];
    case (heading_d)
      2'b00:   nr = head_cur[5:3] - 3'd1;
      2'b01:   nc = head_cur[2:0] + 3'd1;
      2'b10:   nr = head_cur[5:3] + 3'd1;
      default: nc = head_cur[2:0] - 3'd1;
    endcase
  end

  always_comb begin
    off_edge = 1'b0;
`ifdef SNAKE_WALL_KILL_EN
    case (heading_d)
      2'b00:   off_edge = (head_cur[5:3] == 3'd0);
      2'b01:   off_edge = (head_cur[2:0] == 3'd7);
      2'b10:   off_edge = (head_cur[5:3] == 3'd7);
      default: off_edge = (head_cur[2:0] == 3'd0);
    endcase
`endif
  end

  // Entering the tail cell is legal unless growing, since the tail vacates.
  always_comb begin
    food_hit = food_valid && ({nr, nc} == {food_row, food_col});
    grow     = food_hit && (length_q < LW'(MAX_LEN));
    tail_idx = head_ptr_q - PW'(length_q - LW'(1));
    tail     = ring_q[tail_idx];
    hit      = off_edge ||
               (green_q[nr][nc] && !(({nr, nc} == tail) && !grow));
    seg_k    = cnt_q - LW'(1);
    seg_idx  = head_ptr_q - PW'(seg_k);
    seg      = ring_q[seg_idx];
    food_frame = '0;
    if (food_valid) food_frame[food_row][food_col] = 1'b1;
  end

  // step is accepted only in RUN (busy low, not over); at any other time it is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_RENDER;
      for (int i = 0; i < MAX_LEN; i++)
        ring_q[i] <= (i < START_LEN) ? {3'd3, i[2:0]} : 6'd0;
      head_ptr_q <= PW'(START_LEN - 1);
      length_q   <= LW'(START_LEN);
      heading_q  <= 2'b01;
      cnt_q      <= '0;
      shadow_q   <= '0;
      red_q      <= '0;
      green_q    <= '0;
      ate_q      <= 1'b0;
      over_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      ate_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (step) begin
            if (hit) begin
              state_q <= S_OVER;
              over_q  <= 1'b1;
              red_q   <= green_q;
              green_q <= '0;
            end else begin
              heading_q  <= heading_d;
              head_ptr_q <= head_ptr_q + PW'(1);
              ring_q[head_ptr_q + PW'(1)] <= {nr, nc};
              if (grow) length_q <= length_q + LW'(1);
              ate_q   <= food_hit;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_RENDER;
            end
          end
        end
        S_RENDER: begin
          cnt_q <= cnt_q + LW'(1);
          if (cnt_q == '0) begin
            shadow_q <= '0;
          end else if (cnt_q <= length_q) begin
            shadow_q[seg[5:3]][seg[2:0]] <= 1'b1;
          end else begin
            green_q <= shadow_q;
            red_q   <= food_frame;
            busy_q  <= 1'b0;
            state_q <= S_RUN;
          end
        end
        S_OVER:  ;
        default: state_q <= S_OVER;
      endcase
    end
  end

  assign red_array   = red_q;
  assign green_array = green_q;
  assign ate         = ate_q;
  assign game_over   = over_q;
  assign busy        = busy_q;
  assign length      = length_q;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Directed bench for snake_body_tracker: reset frame, growth, reversal, wrap,
// tail-chasing loops, dropped steps and asynchronous reset.
module tb_snake_body_tracker;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            step = 1'b0;
  logic [1:0]      dir = 2'b01;
  logic            food_valid = 1'b0;
  logic [2:0]      food_row = 3'd0;
  logic [2:0]      food_col = 3'd0;
  logic [7:0][7:0] red_array, green_array;
  logic            ate, game_over, busy;
  logic [4:0]      length;

  int errors = 0;
  int checks = 0;

  snake_body_tracker dut (
    .clock(clock), .reset(reset), .step(step), .dir(dir),
    .food_valid(food_valid), .food_row(food_row), .food_col(food_col),
    .red_array(red_array), .green_array(green_array), .ate(ate),
    .game_over(game_over), .busy(busy), .length(length)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_step(input logic [1:0] d);
    @(negedge clock);
    dir  = d;
    step = 1'b1;
    @(posedge clock);
    #1;
    step = 1'b0;
  endtask

  // Counts remaining busy cycles, bounded so a stuck DUT still reaches the summary.
  task automatic wait_render(input int exp_n, input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(tag, 64'(n), 64'(exp_n));
  endtask

  task automatic do_reset();
    step  = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_render(5, "reset_busy_len");
  endtask

  initial begin
    // Reset values and first frame
    @(posedge clock);
    #1;
    check("rst_busy", 64'(busy), 64'd1);
    check("rst_green", green_array, 64'd0);
    check("rst_red", red_array, 64'd0);
    check("rst_over", 64'(game_over), 64'd0);
    check("rst_ate", 64'(ate), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_render(5, "first_frame_busy");
    check("init_green3", 64'(green_array[3]), 64'h07);
    check("init_red", red_array, 64'd0);
    check("init_len", 64'(length), 64'd3);
    check("init_busy", 64'(busy), 64'd0);

    // Eat food at (3,3)
    food_valid = 1'b1; food_row = 3'd3; food_col = 3'd3;
    do_step(2'b01);
    check("eat_ate", 64'(ate), 64'd1);
    check("eat_len", 64'(length), 64'd4);
    check("eat_busy", 64'(busy), 64'd1);
    @(posedge clock);
    #1;
    check("eat_ate_pulse", 64'(ate), 64'd0);
    wait_render(5, "eat_busy_len");
    check("eat_green3", 64'(green_array[3]), 64'h0F);
    check("eat_red3", 64'(red_array[3]), 64'h08);

    // Reversal request is ignored
    food_valid = 1'b0;
    do_step(2'b11);
    check("rev_ate", 64'(ate), 64'd0);
    wait_render(6, "rev_busy_len");
    check("rev_green3", 64'(green_array[3]), 64'h1E);
    check("rev_red", red_array, 64'd0);
    check("rev_over", 64'(game_over), 64'd0);

    // Run to the right edge
    repeat (3) begin
      do_step(2'b01);
      wait_render(6, "edge_busy_len");
    end
    check("edge_green3", 64'(green_array[3]), 64'hF0);
    do_step(2'b01);
`ifdef SNAKE_WALL_KILL_EN
    check("wall_over", 64'(game_over), 64'd1);
    check("wall_red3", 64'(red_array[3]), 64'hF0);
    check("wall_green", green_array, 64'd0);
`else
    wait_render(6, "wrap_busy_len");
    check("wrap_green3", 64'(green_array[3]), 64'hE1);
    check("wrap_over", 64'(game_over), 64'd0);
`endif

    // Length-4 square loop onto the vacating tail
    do_reset();
    food_valid = 1'b1; food_row = 3'd3; food_col = 3'd3;
    do_step(2'b01);
    wait_render(6, "sq4_grow_busy");
    food_valid = 1'b0;
    do_step(2'b01); wait_render(6, "sq4_r");
    do_step(2'b10); wait_render(6, "sq4_d");
    do_step(2'b11); wait_render(6, "sq4_l");
    do_step(2'b00); wait_render(6, "sq4_u");
    check("sq4_over", 64'(game_over), 64'd0);
    check("sq4_green3", 64'(green_array[3]), 64'h18);
    check("sq4_green4", 64'(green_array[4]), 64'h18);
    check("sq4_len", 64'(length), 64'd4);

    // Length-5 square loop hits its own body
    do_reset();
    food_valid = 1'b1; food_row = 3'd3; food_col = 3'd3;
    do_step(2'b01); wait_render(6, "sq5_g1");
    food_col = 3'd4;
    do_step(2'b01); wait_render(7, "sq5_g2");
    food_valid = 1'b0;
    do_step(2'b01); wait_render(7, "sq5_r");
    do_step(2'b10); wait_render(7, "sq5_d");
    do_step(2'b11); wait_render(7, "sq5_l");
    do_step(2'b00);
    check("sq5_over", 64'(game_over), 64'd1);
    check("sq5_red3", 64'(red_array[3]), 64'h38);
    check("sq5_red4", 64'(red_array[4]), 64'h30);
    check("sq5_green", green_array, 64'd0);
    check("sq5_len", 64'(length), 64'd5);
    check("sq5_busy", 64'(busy), 64'd0);
    do_step(2'b01);
    check("over_frozen_red3", 64'(red_array[3]), 64'h38);
    check("over_frozen_busy", 64'(busy), 64'd0);
    #2 reset = 1'b1;
    #1;
    check("over_rst_over", 64'(game_over), 64'd0);
    check("over_rst_red", red_array, 64'd0);
    check("over_rst_busy", 64'(busy), 64'd1);

    // Step while busy is dropped
    @(negedge clock);
    reset = 1'b0;
    wait_render(5, "drop_init_busy");
    do_step(2'b01);
    do_step(2'b10);
    wait_render(4, "drop_busy_len");
    check("drop_green3", 64'(green_array[3]), 64'h0E);
    check("drop_green4", 64'(green_array[4]), 64'h00);
    @(posedge clock);
    #1;
    check("drop_no_restart", 64'(busy), 64'd0);

    // Asynchronous reset during render
    do_step(2'b01);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_green", green_array, 64'd0);
    check("midrst_red", red_array, 64'd0);
    check("midrst_over", 64'(game_over), 64'd0);
    check("midrst_busy", 64'(busy), 64'd1);
    @(negedge clock);
    reset = 1'b0;
    wait_render(5, "midrst_busy_len");
    check("midrst_green3", 64'(green_array[3]), 64'h07);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
